// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel filter.
package sobel_pkg;

   typedef enum logic [1:0] {
      S_HDR_W,
      S_HDR_H,
      S_PIXELS,
      S_DISCARD
   } state_e;

   typedef enum logic [1:0] {
      MODE_MAG,
      MODE_GX,
      MODE_GY,
      MODE_THRESH
   } mode_e;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int GRAD_W         = DATA_WIDTH_DEF + 4;

   // Absolute value clamped to the largest unsigned number of the given width.
   function automatic int sat_abs(input int value, input int width);
      int magnitude;
      int limit;
      magnitude = (value < 0) ? -value : value;
      limit     = (1 << width) - 1;
      return (magnitude > limit) ? limit : magnitude;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line buffer: row1 holds the previous image row, row2 the row before it.
module sobel_line_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WIDTH  = 256,
   parameter int ADDR_W     = $clog2(MAX_WIDTH)
) (
   input  logic                  clk,
   input  logic                  i_wrEn,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [DATA_WIDTH-1:0] i_pixel,
   output logic [DATA_WIDTH-1:0] o_row1,
   output logic [DATA_WIDTH-1:0] o_row2
);

   logic [DATA_WIDTH-1:0] r_row1Mem [0:MAX_WIDTH-1];
   logic [DATA_WIDTH-1:0] r_row2Mem [0:MAX_WIDTH-1];

   // Reads are combinational, so the write cycle still sees the old contents.
   always_ff @(posedge clk) begin
      if (i_wrEn) begin
         r_row1Mem[i_addr] <= i_pixel;
         r_row2Mem[i_addr] <= r_row1Mem[i_addr];
      end
   end

   assign o_row1 = r_row1Mem[i_addr];
   assign o_row2 = r_row2Mem[i_addr];

endmodule

// File: rtl/sobel_stream_filter.sv
// Framed valid/ready Sobel filter: width and height header words, then W*H pixels.
module sobel_stream_filter
   import sobel_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_WIDTH  = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   output logic                  ready_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   input  logic                  ready_out,
   input  logic [1:0]            mode,
   input  logic [DATA_WIDTH-1:0] thresh,
   output logic                  frame_done,
   output logic                  frame_err
);

   localparam int COL_W     = $clog2(MAX_WIDTH + 1);
   localparam int ADDR_W    = $clog2(MAX_WIDTH);
   localparam int GRAD_BITS = DATA_WIDTH + 4;
   localparam int CNT_W     = 2 * DATA_WIDTH;

   state_e                r_state;
   state_e                w_nextState;
   logic [DATA_WIDTH-1:0] r_width;
   logic [DATA_WIDTH-1:0] r_height;
   mode_e                 r_mode;
   logic [DATA_WIDTH-1:0] r_thresh;
   logic [COL_W-1:0]      r_col;
   logic [COL_W-1:0]      r_row;
   logic [CNT_W-1:0]      r_discardLeft;
   logic [DATA_WIDTH-1:0] r_win [0:2][0:1];
   logic                  r_validOut;
   logic [DATA_WIDTH-1:0] r_dataOut;
   logic                  r_frameDone;
   logic                  r_frameErr;

   logic                  w_accept;
   logic                  w_pixReady;
   logic                  w_hdrBad;
   logic                  w_hdrEmpty;
   logic                  w_lastCol;
   logic                  w_lastRow;
   logic                  w_lastDiscard;
   logic                  w_pixelAccept;
   logic                  w_emit;
   logic [DATA_WIDTH-1:0] w_row1;
   logic [DATA_WIDTH-1:0] w_row2;
   logic signed [GRAD_BITS-1:0] w_gx;
   logic signed [GRAD_BITS-1:0] w_gy;
   int                    w_absX;
   int                    w_absY;
   int                    w_mag;
   logic [DATA_WIDTH-1:0] w_result;

   function automatic logic signed [GRAD_BITS-1:0] ext(input logic [DATA_WIDTH-1:0] p);
      return $signed({4'b0000, p});
   endfunction

   assign w_pixReady    = !r_validOut || ready_out;
   assign w_accept      = valid_in && ready_in;
   assign w_hdrBad      = (int'(r_width) < 3) || (int'(data_in) < 3) || (int'(r_width) > MAX_WIDTH);
   assign w_hdrEmpty    = (r_width == '0) || (data_in == '0);
   assign w_lastCol     = (int'(r_col) == int'(r_width) - 1);
   assign w_lastRow     = (int'(r_row) == int'(r_height) - 1);
   assign w_lastDiscard = (r_discardLeft == CNT_W'(1));
   assign w_pixelAccept = w_accept && (r_state == S_PIXELS);
   assign w_emit        = w_pixelAccept && (r_row >= COL_W'(2)) && (r_col >= COL_W'(2));

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_HDR_W;
      else     r_state <= w_nextState;
   end

   // In pixel mode the input stalls only while a result waits in the output register.
   always_comb begin
      w_nextState = r_state;
      ready_in    = 1'b0;
      case (r_state)
         S_HDR_W: begin
            ready_in = 1'b1;
            if (valid_in) w_nextState = S_HDR_H;
         end
         S_HDR_H: begin
            ready_in = 1'b1;
            if (valid_in) begin
               if (w_hdrBad) w_nextState = w_hdrEmpty ? S_HDR_W : S_DISCARD;
               else          w_nextState = S_PIXELS;
            end
         end
         S_PIXELS: begin
            ready_in = w_pixReady;
            if (valid_in && w_pixReady && w_lastCol && w_lastRow) w_nextState = S_HDR_W;
         end
         S_DISCARD: begin
            ready_in = 1'b1;
            if (valid_in && w_lastDiscard) w_nextState = S_HDR_W;
         end
         default: w_nextState = S_HDR_W;
      endcase
      if (rst) ready_in = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_width       <= '0;
         r_height      <= '0;
         r_mode        <= MODE_MAG;
         r_thresh      <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_discardLeft <= '0;
         r_frameDone   <= 1'b0;
         r_frameErr    <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         r_frameErr  <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_HDR_W: r_width <= data_in;
               S_HDR_H: begin
                  r_height      <= data_in;
                  r_mode        <= mode_e'(mode);
                  r_thresh      <= thresh;
                  r_col         <= '0;
                  r_row         <= '0;
                  r_discardLeft <= CNT_W'(r_width) * CNT_W'(data_in);
                  r_frameErr    <= w_hdrBad;
               end
               S_PIXELS: begin
                  if (w_lastCol) begin
                     r_col <= '0;
                     r_row <= r_row + COL_W'(1);
                     if (w_lastRow) r_frameDone <= 1'b1;
                  end else begin
                     r_col <= r_col + COL_W'(1);
                  end
               end
               S_DISCARD: begin
                  r_discardLeft <= r_discardLeft - CNT_W'(1);
                  if (w_lastDiscard) r_frameDone <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   sobel_line_buffer #(
      .DATA_WIDTH(DATA_WIDTH),
      .MAX_WIDTH (MAX_WIDTH),
      .ADDR_W    (ADDR_W)
   ) u_lineBuffer (
      .clk    (clk),
      .i_wrEn (w_pixelAccept),
      .i_addr (ADDR_W'(r_col)),
      .i_pixel(data_in),
      .o_row1 (w_row1),
      .o_row2 (w_row2)
   );

   // The incoming column (row2, row1, data_in) completes the 3x3 window with these two.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            r_win[i][0] <= '0;
            r_win[i][1] <= '0;
         end
      end else if (w_pixelAccept) begin
         r_win[0][0] <= r_win[0][1];
         r_win[1][0] <= r_win[1][1];
         r_win[2][0] <= r_win[2][1];
         r_win[0][1] <= w_row2;
         r_win[1][1] <= w_row1;
         r_win[2][1] <= data_in;
      end
   end

   always_comb begin
      w_gx = (ext(w_row2) + ext(w_row1) + ext(w_row1) + ext(data_in))
           - (ext(r_win[0][0]) + ext(r_win[1][0]) + ext(r_win[1][0]) + ext(r_win[2][0]));
      w_gy = (ext(r_win[2][0]) + ext(r_win[2][1]) + ext(r_win[2][1]) + ext(data_in))
           - (ext(r_win[0][0]) + ext(r_win[0][1]) + ext(r_win[0][1]) + ext(w_row2));
   end

   always_comb begin
      w_absX   = sat_abs(int'(w_gx), 30);
      w_absY   = sat_abs(int'(w_gy), 30);
      w_mag    = w_absX + w_absY;
      w_result = '0;
      case (r_mode)
         MODE_MAG:    w_result = DATA_WIDTH'(sat_abs(w_mag, DATA_WIDTH));
         MODE_GX:     w_result = DATA_WIDTH'(sat_abs(w_absX, DATA_WIDTH));
         MODE_GY:     w_result = DATA_WIDTH'(sat_abs(w_absY, DATA_WIDTH));
         MODE_THRESH: w_result = (w_mag >= int'(r_thresh)) ? '1 : '0;
         default:     w_result = '0;
      endcase
   end

   // A new result may only replace the held one when it is being consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_validOut <= 1'b0;
         r_dataOut  <= '0;
      end else if (w_emit) begin
         r_validOut <= 1'b1;
         r_dataOut  <= w_result;
      end else if (ready_out) begin
         r_validOut <= 1'b0;
      end
   end

   assign data_out   = r_dataOut;
   assign valid_out  = r_validOut;
   assign frame_done = r_frameDone;
   assign frame_err  = r_frameErr;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter with an image-level Sobel reference model.
module tb_sobel_stream_filter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       ready_out;
   logic [1:0] mode;
   logic [7:0] thresh;
   logic       frame_done;
   logic       frame_err;

   int vectors     = 0;
   int miscompares = 0;
   int expQ[$];
   int gotQ[$];
   int doneCnt = 0;
   int errCnt  = 0;
   int img[0:63];
   bit holdPending = 1'b0;
   int holdData    = 0;

   always #5 clk = ~clk;

   sobel_stream_filter dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .mode      (mode),
      .thresh    (thresh),
      .frame_done(frame_done),
      .frame_err (frame_err)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: Sobel over the whole image, interior centres in row-major order.
   function automatic void modelFrame(input int w, input int h, input int md, input int th);
      for (int r = 1; r <= h - 2; r++) begin
         for (int c = 1; c <= w - 2; c++) begin
            int gx, gy, ax, ay, res;
            gx = (img[(r-1)*w+c+1] + 2*img[r*w+c+1] + img[(r+1)*w+c+1])
               - (img[(r-1)*w+c-1] + 2*img[r*w+c-1] + img[(r+1)*w+c-1]);
            gy = (img[(r+1)*w+c-1] + 2*img[(r+1)*w+c] + img[(r+1)*w+c+1])
               - (img[(r-1)*w+c-1] + 2*img[(r-1)*w+c] + img[(r-1)*w+c+1]);
            ax = (gx < 0) ? -gx : gx;
            ay = (gy < 0) ? -gy : gy;
            case (md)
               0:       res = (ax + ay > 255) ? 255 : ax + ay;
               1:       res = (ax > 255) ? 255 : ax;
               2:       res = (ay > 255) ? 255 : ay;
               default: res = (ax + ay >= th) ? 255 : 0;
            endcase
            expQ.push_back(res);
         end
      end
   endfunction

   // Compare process: every consumed output is checked against the model queue.
   always @(negedge clk) begin : cmp
      int e;
      if (!rst) begin
         if (holdPending) begin
            checkOutput("held_valid", int'(valid_out), 1);
            checkOutput("held_data", int'(data_out), holdData);
         end
         holdPending = valid_out && !ready_out;
         holdData    = int'(data_out);
         if (valid_out && ready_out) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_output", int'(valid_out), 0);
            end else begin
               e = expQ.pop_front();
               checkOutput("model_output", int'(data_out), e);
            end
            gotQ.push_back(int'(data_out));
         end
         doneCnt += int'(frame_done);
         errCnt  += int'(frame_err);
      end else begin
         holdPending = 1'b0;
      end
   end

   task automatic applyStimulus(input logic [7:0] word);
      bit acc   = 1'b0;
      int guard = 0;
      data_in  = word;
      valid_in = 1'b1;
      while (!acc && guard < 200) begin
         @(negedge clk);
         acc = ready_in;
         @(posedge clk);
         #1;
         guard++;
      end
      valid_in = 1'b0;
      if (!acc) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL accept_timeout: word %0d not accepted in 200 cycles, required acceptance", word);
      end
   endtask

   task automatic sendFrame(input int w, input int h, input int md, input int th, input int nPix);
      mode   = 2'(md);
      thresh = 8'(th);
      applyStimulus(8'(w));
      applyStimulus(8'(h));
      for (int i = 0; i < nPix; i++) applyStimulus(8'(img[i]));
   endtask

   task automatic drain();
      ready_out = 1'b1;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic rampImage();
      for (int i = 0; i < 64; i++) img[i] = (i < 20) ? i : 0;
   endtask

   initial begin : watchdog
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int d0, e0;
      rst       = 1'b1;
      valid_in  = 1'b0;
      data_in   = '0;
      ready_out = 1'b1;
      mode      = '0;
      thresh    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_ready_in", int'(ready_in), 0);
      checkOutput("rst_valid_out", int'(valid_out), 0);
      checkOutput("rst_data_out", int'(data_out), 0);
      checkOutput("rst_frame_done", int'(frame_done), 0);
      checkOutput("rst_frame_err", int'(frame_err), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 5x4 ramp, magnitude mode
      $display("[TB] 5x4 ramp, magnitude");
      rampImage();
      modelFrame(5, 4, 0, 0);
      checkOutput("pin_mag", expQ[0], 48);
      d0 = doneCnt;
      sendFrame(5, 4, 0, 0, 20);
      drain();
      checkOutput("mag_count", gotQ.size(), 6);
      checkOutput("mag_first", gotQ[0], 48);
      checkOutput("mag_last", gotQ[5], 48);
      checkOutput("mag_done", doneCnt - d0, 1);
      gotQ.delete();

      // Four frames back to back in the other modes
      $display("[TB] back-to-back frames in modes 1,2,3,3");
      modelFrame(5, 4, 1, 0);
      checkOutput("pin_gx", expQ[expQ.size()-1], 8);
      modelFrame(5, 4, 2, 0);
      checkOutput("pin_gy", expQ[expQ.size()-1], 40);
      modelFrame(5, 4, 3, 49);
      checkOutput("pin_th49", expQ[expQ.size()-1], 0);
      modelFrame(5, 4, 3, 48);
      checkOutput("pin_th48", expQ[expQ.size()-1], 255);
      d0 = doneCnt;
      sendFrame(5, 4, 1, 0, 20);
      sendFrame(5, 4, 2, 0, 20);
      sendFrame(5, 4, 3, 49, 20);
      sendFrame(5, 4, 3, 48, 20);
      drain();
      checkOutput("modes_count", gotQ.size(), 24);
      checkOutput("gx_value", gotQ[0], 8);
      checkOutput("gy_value", gotQ[6], 40);
      checkOutput("th49_value", gotQ[12], 0);
      checkOutput("th48_value", gotQ[23], 255);
      checkOutput("modes_done", doneCnt - d0, 4);
      gotQ.delete();

      // Saturation: bright bottom row only
      $display("[TB] 3x3 saturation");
      for (int i = 0; i < 64; i++) img[i] = (i >= 6 && i < 9) ? 255 : 0;
      modelFrame(3, 3, 0, 0);
      checkOutput("pin_sat", expQ[0], 255);
      sendFrame(3, 3, 0, 0, 9);
      drain();
      checkOutput("sat_count", gotQ.size(), 1);
      checkOutput("sat_value", gotQ[0], 255);
      gotQ.delete();

      // Backpressure after the first output
      $display("[TB] backpressure");
      rampImage();
      modelFrame(5, 4, 0, 0);
      fork
         sendFrame(5, 4, 0, 0, 20);
         begin : stall
            int g = 0;
            while (!valid_out && g < 500) begin
               @(negedge clk);
               g++;
            end
            if (!valid_out) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL bp_wait: valid_out 0 after 500 cycles, required 1");
            end
            @(posedge clk);
            #1;
            ready_out = 1'b0;
            repeat (3) @(negedge clk);
            checkOutput("bp_ready_in_low", int'(ready_in), 0);
            checkOutput("bp_valid_held", int'(valid_out), 1);
            repeat (7) @(posedge clk);
            #1;
            ready_out = 1'b1;
         end
      join
      drain();
      checkOutput("bp_count", gotQ.size(), 6);
      foreach (gotQ[i]) checkOutput("bp_value", gotQ[i], 48);
      gotQ.delete();

      // Illegal header W=2,H=4: eight words dropped, then a good frame
      $display("[TB] illegal header");
      e0 = errCnt;
      d0 = doneCnt;
      mode = 2'd0;
      applyStimulus(8'd2);
      applyStimulus(8'd4);
      for (int i = 0; i < 8; i++) applyStimulus(8'(i * 30));
      drain();
      checkOutput("err_pulse", errCnt - e0, 1);
      checkOutput("err_no_output", gotQ.size(), 0);
      checkOutput("err_discard_done", doneCnt - d0, 1);
      rampImage();
      modelFrame(5, 4, 0, 0);
      sendFrame(5, 4, 0, 0, 20);
      drain();
      checkOutput("post_err_count", gotQ.size(), 6);
      checkOutput("post_err_value", gotQ[0], 48);
      gotQ.delete();

      // Reset after 12 pixels, then a complete frame
      $display("[TB] reset mid-frame");
      sendFrame(5, 4, 0, 0, 12);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midrst_valid_out", int'(valid_out), 0);
      checkOutput("midrst_ready_in", int'(ready_in), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      d0 = doneCnt;
      modelFrame(5, 4, 0, 0);
      sendFrame(5, 4, 0, 0, 20);
      drain();
      checkOutput("midrst_count", gotQ.size(), 6);
      checkOutput("midrst_first", gotQ[0], 48);
      checkOutput("midrst_last", gotQ[5], 48);
      checkOutput("midrst_done", doneCnt - d0, 1);
      checkOutput("model_queue_empty", expQ.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
